// File: rtl/ofm_col_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofm_col_arbiter_pkg
// Brief    : Shared CU33 constants and sum type for the OFM column arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ofm_col_arbiter_pkg;

  localparam int CU_COL        = 8;
  localparam int CU_OFM_WIDTH  = 32;
  localparam int CU_FIFO_DEPTH = 4;
  localparam int CU_TILE_LEN   = 16;

  typedef logic [CU_OFM_WIDTH-1:0] sum_t;

endpackage
`default_nettype wire

// File: rtl/ofm_col_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ofm_col_arbiter_if
// Brief    : Kernel-side sum lanes and downstream word stream of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ofm_col_arbiter_if
  import ofm_col_arbiter_pkg::*;
#(
  parameter int COL = CU_COL
);

  logic                   clear;
  logic [COL-1:0]         sum_valid;
  sum_t                   sum [COL];
  logic                   out_valid;
  logic                   out_ready;
  sum_t                   out_data;
  logic [$clog2(COL)-1:0] out_col;
  logic                   out_eol;
  logic [COL-1:0]         ovf_err;
  logic                   idle;

  modport master (
    output clear, sum_valid, sum, out_ready,
    input  out_valid, out_data, out_col, out_eol, ovf_err, idle
  );

  modport slave (
    input  clear, sum_valid, sum, out_ready,
    output out_valid, out_data, out_col, out_eol, ovf_err, idle
  );

endinterface
`default_nettype wire

// File: rtl/ofm_col_arbiter_col_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ofm_col_arbiter_col_fifo
// Brief    : Per-column sum FIFO; a push into a full FIFO is dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_col_arbiter_col_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign w_pop   = pop_i && !empty_o;
  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign w_push  = push_i && !clear && (!full_o || w_pop);
  assign ovf_o   = push_i && !clear && full_o && !w_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_push && w_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/ofm_col_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ofm_col_arbiter
// Brief    : Round-robin merge of COL per-column sum FIFOs into one word stream.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_col_arbiter
  import ofm_col_arbiter_pkg::*;
#(
  parameter int COL        = CU_COL,
  parameter int OFM_WIDTH  = CU_OFM_WIDTH,
  parameter int FIFO_DEPTH = CU_FIFO_DEPTH,
  parameter int TILE_LEN   = CU_TILE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  ofm_col_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(COL);
  localparam int LC_W  = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

  logic [OFM_WIDTH-1:0] w_head [COL];
  logic [COL-1:0]       w_empty, w_full, w_ovf, w_pop;
  logic [LC_W-1:0]      line_cnt_q [COL];
  logic [IDX_W-1:0]     w_cand, gnt_idx;
  logic                 gnt_found, w_load;

  logic                 out_valid_q, out_valid_d, out_eol_q, out_eol_d;
  logic [OFM_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_col_q, out_col_d, rr_ptr_q, rr_ptr_d;
  logic [COL-1:0]       ovf_err_q, ovf_err_d;

  for (genvar c = 0; c < COL; c++) begin : g_col
    assign w_pop[c] = w_load && gnt_found && (gnt_idx == IDX_W'(c)) && !bus.clear;

    ofm_col_arbiter_col_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OFM_WIDTH)
    ) u_col_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (bus.clear),
      .push_i  (bus.sum_valid[c]),
      .pop_i   (w_pop[c]),
      .din_i   (bus.sum[c]),
      .full_o  (w_full[c]),
      .empty_o (w_empty[c]),
      .ovf_o   (w_ovf[c]),
      .head_o  (w_head[c])
    );
  end

  assign w_load = !out_valid_q || bus.out_ready;

  // First non-empty column at or after rr_ptr, wrapping past COL-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    w_cand    = '0;
    for (int k = 0; k < COL; k++) begin
      w_cand = IDX_W'((int'(rr_ptr_q) + k) % COL);
      if (!gnt_found && !w_empty[w_cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = w_cand;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    rr_ptr_d    = rr_ptr_q;
    ovf_err_d   = ovf_err_q | w_ovf;
    if (bus.clear) begin
      out_valid_d = 1'b0;
      rr_ptr_d    = '0;
      ovf_err_d   = '0;
    end else if (w_load) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_data_d = w_head[gnt_idx];
        out_col_d  = gnt_idx;
        out_eol_d  = (line_cnt_q[gnt_idx] == LC_W'(TILE_LEN - 1));
        rr_ptr_d   = (gnt_idx == IDX_W'(COL - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
      rr_ptr_q    <= '0;
      ovf_err_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COL; c++) line_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (bus.clear)
          line_cnt_q[c] <= '0;
        else if (w_pop[c])
          line_cnt_q[c] <= (line_cnt_q[c] == LC_W'(TILE_LEN - 1)) ? '0 : line_cnt_q[c] + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.idle      = (&w_empty) && !out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ofm_col_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_col_arbiter
// Brief    : Directed self-checking bench for ofm_col_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_col_arbiter;
  import ofm_col_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ofm_col_arbiter_if bus ();

  ofm_col_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sum_valid = '0;
    for (int c = 0; c < CU_COL; c++) bus.sum[c] = '0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%0h exp=0", bus.out_data); end
    n_checks++; if (bus.out_col !== 3'd0 || bus.out_eol !== 1'b0) begin n_fail++; $display("FAIL reset_col_eol got=%0d/%b exp=0/0", bus.out_col, bus.out_eol); end
    n_checks++; if (bus.ovf_err !== 8'h00 || bus.idle !== 1'b1) begin n_fail++; $display("FAIL reset_ovf_idle got=%0h/%b exp=0/1", bus.ovf_err, bus.idle); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_clear();
    bus.out_ready = 1'b1;
    bus.sum_valid = 8'b0000_0100;
    bus.sum[2] = 32'd7;
    step();
    idle_inputs();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.idle !== 1'b0) begin n_fail++; $display("FAIL single_t0 valid/idle got=%b/%b exp=0/0", bus.out_valid, bus.idle); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd7 || bus.out_col !== 3'd2)
      begin n_fail++; $display("FAIL single_word got v=%b d=%0d c=%0d exp v=1 d=7 c=2", bus.out_valid, bus.out_data, bus.out_col); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.idle !== 1'b1) begin n_fail++; $display("FAIL single_drain valid/idle got=%b/%b exp=0/1", bus.out_valid, bus.idle); end
  endtask

  task automatic test_all_cols();
    do_clear();
    bus.out_ready = 1'b1;
    bus.sum_valid = 8'hFF;
    for (int c = 0; c < CU_COL; c++) bus.sum[c] = 32'(c);
    step();
    idle_inputs();
    for (int i = 0; i < CU_COL; i++) begin
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_col !== 3'(i) || bus.out_data !== 32'(i))
        begin n_fail++; $display("FAIL all_cols[%0d] got v=%b c=%0d d=%0d exp v=1 c=%0d d=%0d", i, bus.out_valid, bus.out_col, bus.out_data, i, i); end
    end
    step();
    n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL all_cols_idle got=%b exp=1", bus.idle); end
  endtask

  task automatic test_round_robin();
    do_clear();
    bus.out_ready = 1'b1;
    bus.sum_valid = 8'b0100_0000;
    bus.sum[6] = 32'd60;
    step();
    bus.sum_valid = 8'b1000_0100;
    bus.sum[2] = 32'd20;
    bus.sum[7] = 32'd70;
    step();
    idle_inputs();
    n_checks++; if (bus.out_data !== 32'd60 || bus.out_col !== 3'd6) begin n_fail++; $display("FAIL rr_first got d=%0d c=%0d exp d=60 c=6", bus.out_data, bus.out_col); end
    step();
    n_checks++; if (bus.out_data !== 32'd70 || bus.out_col !== 3'd7) begin n_fail++; $display("FAIL rr_second got d=%0d c=%0d exp d=70 c=7", bus.out_data, bus.out_col); end
    step();
    n_checks++; if (bus.out_data !== 32'd20 || bus.out_col !== 3'd2) begin n_fail++; $display("FAIL rr_wrap got d=%0d c=%0d exp d=20 c=2", bus.out_data, bus.out_col); end
    step();
  endtask

  task automatic test_overflow();
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sum_valid = 8'h01;
      bus.sum[0] = 32'(100 + i);
      step();
    end
    idle_inputs();
    n_checks++; if (bus.ovf_err !== 8'h01) begin n_fail++; $display("FAIL ovf_flag got=%0h exp=01", bus.ovf_err); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(100 + i))
        begin n_fail++; $display("FAIL ovf_word[%0d] got v=%b d=%0d exp v=1 d=%0d", i, bus.out_valid, bus.out_data, 100 + i); end
      step();
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.idle !== 1'b1) begin n_fail++; $display("FAIL ovf_drain valid/idle got=%b/%b exp=0/1", bus.out_valid, bus.idle); end
    n_checks++; if (bus.ovf_err !== 8'h01) begin n_fail++; $display("FAIL ovf_sticky got=%0h exp=01", bus.ovf_err); end
  endtask

  task automatic test_eol();
    int nrecv;
    nrecv = 0;
    do_clear();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (cyc < 32) begin
        bus.sum_valid = 8'b0000_1000;
        bus.sum[3] = 32'(cyc);
      end else begin
        idle_inputs();
      end
      step();
      if (bus.out_valid === 1'b1) begin
        n_checks++; if (bus.out_data !== 32'(nrecv) || bus.out_eol !== (nrecv == 15 || nrecv == 31))
          begin n_fail++; $display("FAIL eol_word[%0d] got d=%0d eol=%b exp d=%0d eol=%b", nrecv, bus.out_data, bus.out_eol, nrecv, (nrecv == 15 || nrecv == 31)); end
        nrecv++;
      end
    end
    n_checks++; if (nrecv != 32) begin n_fail++; $display("FAIL eol_count got=%0d exp=32", nrecv); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sum_valid = 8'h01;
      bus.sum[0] = 32'(200 + i);
      step();
    end
    bus.out_ready = 1'b1;
    bus.sum[0] = 32'd205;
    step();
    idle_inputs();
    n_checks++; if (bus.ovf_err !== 8'h00 || bus.out_data !== 32'd201)
      begin n_fail++; $display("FAIL full_pp got ovf=%0h d=%0d exp ovf=0 d=201", bus.ovf_err, bus.out_data); end
    for (int i = 2; i <= 5; i++) begin
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(200 + i))
        begin n_fail++; $display("FAIL full_pp_order[%0d] got v=%b d=%0d exp v=1 d=%0d", i, bus.out_valid, bus.out_data, 200 + i); end
    end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_rst_clear();
    bit seen;
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sum_valid = 8'h02;
      bus.sum[1] = 32'(300 + i);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.idle !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid got v=%b d=%0d idle=%b exp v=0 d=0 idle=1", bus.out_valid, bus.out_data, bus.idle); end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_stale got=word exp=none"); end

    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sum_valid = 8'h20;
      bus.sum[5] = 32'(500 + i);
      step();
    end
    idle_inputs();
    n_checks++; if (bus.ovf_err !== 8'h20) begin n_fail++; $display("FAIL clr_ovf_set got=%0h exp=20", bus.ovf_err); end
    bus.clear = 1'b1;
    bus.sum_valid = 8'h10;
    bus.sum[4] = 32'd444;
    step();
    bus.clear = 1'b0;
    idle_inputs();
    n_checks++; if (bus.ovf_err !== 8'h00 || bus.out_valid !== 1'b0 || bus.idle !== 1'b1)
      begin n_fail++; $display("FAIL clr_state got ovf=%0h v=%b idle=%b exp ovf=0 v=0 idle=1", bus.ovf_err, bus.out_valid, bus.idle); end
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL clr_stale got=word exp=none"); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_all_cols();
    test_round_robin();
    test_overflow();
    test_eol();
    test_full_push_pop();
    test_rst_clear();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
